chunked_seq_adder: RTL and testbench
====================================

// Module: chunked_seq_adder
// PURPOSE
//  Parametrised multi-cycle adder/subtractor. It is the sequential successor to the
//  4-bit combinational full adder.
//  - Processes a WIDTH-bit operand pair CHUNK bits per clock, least significant chunk first.
//  - The carry is kept in a register between chunks.
//  - Valid/ready handshake on both the input side and the output side.
//  - Intended for datapaths too wide for one-cycle ripple carry.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be a multiple of CHUNK
//  CHUNK   4  bits added per clock; NCH = WIDTH/CHUNK chunks per operation
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous active-low reset, sampled on the rising edge of clk
//  in_valid   in   1      operands valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  c_in       in   1      carry-in (add) / borrow-in (sub)
//  sub        in   1      0: add, 1: subtract
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  s          out  WIDTH  result
//  c_out      out  1      carry out of the MSB (sub: 1 = no borrow)
//  ovf        out  1      two's-complement signed overflow
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - state=IDLE, chunk counter=0, carry reg=0.
//   - s=0, c_out=0, ovf=0, out_valid=0, in_ready=1 (in_ready follows IDLE).
//   - Reset wins over every other event, including mid-RUN.
//   - A partial result is discarded and never presented.
//  Arithmetic:
//   - sub=0: {c_out,s} = a + b + c_in.
//   - sub=1: {c_out,s} = a + ~b + ~c_in, i.e. s = a - b - c_in mod 2^WIDTH.
//   - ovf = (a[MSB] == b_eff[MSB]) && (s[MSB] != a[MSB]), where b_eff = b or ~b.
//   - All results wrap modulo 2^WIDTH; no saturation.
//  FSM states:
//   - IDLE:
//     - in_ready=1.
//     - When in_valid&&in_ready, capture a, b_eff and the effective carry-in;
//       set cnt=0; go to RUN.
//     - Operand changes after the accept edge have no effect.
//   - RUN:
//     - in_ready=0.
//     - Each cycle, add chunk cnt of a and b_eff plus the carry reg.
//     - Write the sum into s[cnt*CHUNK +: CHUNK]; update the carry reg; increment cnt.
//     - On the edge that processes chunk NCH-1:
//       - latch c_out and ovf;
//       - go to DONE;
//       - out_valid goes to 1 on this edge.
//     - Latency: out_valid is first seen NCH cycles after the accept edge.
//   - DONE:
//     - out_valid=1; s, c_out and ovf are stable.
//     - While out_ready=0: hold all outputs and stay in DONE (backpressure).
//     - On out_valid&&out_ready: go to IDLE and drop out_valid.
//     - s, c_out and ovf keep their last values until the next result is written.
//     - in_ready=0 in DONE, so there is no same-cycle accept; the next accept is possible
//       one cycle later.
//  Throughput: one operation per NCH+2 cycles with out_ready tied high.
//  in_valid is ignored outside IDLE; no operand queueing.
//  NCH=1 (CHUNK=WIDTH) is legal: RUN lasts one cycle.
//  s is undefined-but-stable during RUN; consumers sample s only when out_valid=1.
// TESTING  (WIDTH=16, CHUNK=4, out_ready=1 unless stated)
//  1 add a=00FF b=0001 c_in=0 -> s=0100 c_out=0 ovf=0; out_valid rises exactly 4 cycles
//    after the accept edge and is high for 1 cycle
//  2 add a=FFFF b=0001 c_in=1 -> s=0001 c_out=1 ovf=0 (wrap plus carry-in through every chunk)
//  3 sub a=0005 b=0007 c_in=0 -> s=FFFE c_out=0 ovf=0
//    sub a=8000 b=0001 c_in=0 -> s=7FFF c_out=1 ovf=1
//  4 add a=7FFF b=0001 c_in=0 -> s=8000 ovf=1; then out_ready=0 for 3 cycles -> out_valid
//    and s held, in_ready=0, a new in_valid is ignored; out_ready=1 -> IDLE next cycle
//  5 rst_n=0 for 1 cycle during the 2nd RUN cycle -> next cycle IDLE, in_ready=1,
//    out_valid=0, s=0; a fresh a=1234 b=1111 add then gives s=2345
//  6 back-to-back: 20 random ops with in_valid held high, compared against a reference
//    model of a+b+c_in / a-b-c_in -> all s, c_out and ovf match; spacing is 6 cycles per op

Source files
------------

// File: rtl/chunked_seq_adder_if.sv
// ----------------------------------------------------------------------------
// chunked_seq_adder_if
//   Handshake bundle for chunked_seq_adder.
//   Input side : in_valid / in_ready, operands a, b, carry/borrow-in c_in, sub.
//   Output side: out_valid / out_ready, result s, carry-out c_out, overflow ovf.
//   master: producer of operands and consumer of results (e.g. a testbench).
//   slave : the adder itself.
// ----------------------------------------------------------------------------
interface chunked_seq_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, s, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, s, c_out, ovf
  );
endinterface

// File: rtl/chunked_seq_adder.sv
// ----------------------------------------------------------------------------
// chunked_seq_adder
//   Multi-cycle adder/subtractor. A WIDTH-bit operand pair is added CHUNK bits
//   per clock, least significant chunk first, with the carry held in a register
//   between chunks. One operation takes NCH = WIDTH/CHUNK RUN cycles.
// Ports
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : chunked_seq_adder_if.slave
//            in_valid/in_ready, a, b, c_in, sub   (operand side)
//            out_valid/out_ready, s, c_out, ovf   (result side)
// ----------------------------------------------------------------------------
module chunked_seq_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  chunked_seq_adder_if.slave   bus
);
  localparam int            NCH  = WIDTH / CHUNK;
  localparam int            CW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;      // b already inverted for subtraction
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK:0]   chunk_sum;
  int               base;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    s_d       = s_q;
    c_out_d   = c_out_q;
    ovf_d     = ovf_q;
    base      = int'(cnt_q) * CHUNK;
    chunk_sum = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Subtraction is a + ~b + ~borrow, so store the effective operand
          // and carry once; RUN then only ever adds.
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? ~bus.c_in : bus.c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
        carry_d            = chunk_sum[CHUNK];
        cnt_d              = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          c_out_d = chunk_sum[CHUNK];
          // Signed overflow: operands agree in sign but the result does not.
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (chunk_sum[CHUNK-1] != a_q[WIDTH-1]);
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operand holding registers carry no reset; they are always loaded on accept.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.s         = s_q;
  assign bus.c_out     = c_out_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_chunked_seq_adder.sv
// ----------------------------------------------------------------------------
// tb_chunked_seq_adder
//   Self-checking bench for chunked_seq_adder (WIDTH=16, CHUNK=4). Expected
//   results are produced by a whole-word reference model when operands are
//   driven, queued, and popped when the DUT presents out_valid.
// ----------------------------------------------------------------------------
module tb_chunked_seq_adder;
  localparam int WIDTH = 16;
  localparam int CHUNK = 4;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chunked_seq_adder_if #(.WIDTH(WIDTH)) bus();

  chunked_seq_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic ci, input logic sb);
    logic [WIDTH-1:0] be;
    logic             ce;
    logic [WIDTH:0]   r;
    exp_t             e;
    be  = sb ? ~b : b;
    ce  = sb ? ~ci : ci;
    r   = {1'b0, a} + {1'b0, be} + {{WIDTH{1'b0}}, ce};
    e.s = r[WIDTH-1:0];
    e.c = r[WIDTH];
    e.o = (a[WIDTH-1] == be[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    return e;
  endfunction

  // Present one operand pair for one accept edge; caller ensures in_ready.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic ci, input logic sb, input bit push);
    bus.a = a; bus.b = b; bus.c_in = ci; bus.sub = sb;
    bus.in_valid = 1'b1;
    if (push) sb_q.push_back(model(a, b, ci, sb));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Bounded wait for out_valid; cycles counts clock edges waited.
  task automatic wait_valid(output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    n_checks++;
    if ({bus.out_valid, bus.s, bus.c_out, bus.ovf} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: out_valid=%b s=%h c_out=%b ovf=%b expected all 0",
               bus.out_valid, bus.s, bus.c_out, bus.ovf);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add_basic;
    int   cyc;
    bit   ok;
    exp_t e, got;
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1);
    wait_valid(cyc, ok);
    n_checks++;
    if (!ok || cyc != 4) begin
      n_fail++; $display("FAIL basic_latency: got %0d cycles (seen=%b) expected 4", cyc, ok);
    end
    e = sb_q.pop_front();
    got = {bus.s, bus.c_out, bus.ovf};
    n_checks++;
    if (got !== e || bus.s !== 16'h0100) begin
      n_fail++; $display("FAIL basic_result: got %h expected %h (s=0100)", got, e);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_pulse: out_valid=%b in_ready=%b expected 0/1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_arith;
    logic [WIDTH-1:0] ta [3] = '{16'hFFFF, 16'h0005, 16'h8000};
    logic [WIDTH-1:0] tb [3] = '{16'h0001, 16'h0007, 16'h0001};
    logic             tc [3] = '{1'b1, 1'b0, 1'b0};
    logic             ts [3] = '{1'b0, 1'b1, 1'b1};
    logic [WIDTH+1:0] lit[3] = '{{16'h0001, 1'b1, 1'b0}, {16'hFFFE, 1'b0, 1'b0},
                                 {16'h7FFF, 1'b1, 1'b1}};
    int   cyc;
    bit   ok;
    exp_t e, got;
    for (int i = 0; i < 3; i++) begin
      send(ta[i], tb[i], tc[i], ts[i], 1'b1);
      wait_valid(cyc, ok);
      e = sb_q.pop_front();
      got = {bus.s, bus.c_out, bus.ovf};
      n_checks++;
      if (!ok || got !== e || got !== lit[i]) begin
        n_fail++;
        $display("FAIL arith_%0d: got %h (seen=%b) expected %h", i, got, ok, lit[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    int   cyc;
    bit   ok;
    exp_t e, got;
    bus.out_ready = 1'b0;
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    wait_valid(cyc, ok);
    e = sb_q.pop_front();
    got = {bus.s, bus.c_out, bus.ovf};
    n_checks++;
    if (!ok || got !== e || bus.s !== 16'h8000 || bus.ovf !== 1'b1) begin
      n_fail++; $display("FAIL bp_result: got %h expected %h", got, e);
    end
    // A new request while DONE must be ignored.
    bus.a = 16'h1111; bus.b = 16'h2222; bus.c_in = 1'b0; bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.s !== e.s) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b s=%h expected 1/0/%h",
                 i, bus.out_valid, bus.in_ready, bus.s, e.s);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.s !== e.s) begin
      n_fail++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b s=%h expected 0/1/%h",
               bus.out_valid, bus.in_ready, bus.s, e.s);
    end
  endtask

  task automatic test_reset_mid_run;
    int   cyc;
    bit   ok;
    exp_t e, got;
    send(16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;        // now in the second RUN cycle
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.s !== 16'h0000) begin
      n_fail++;
      $display("FAIL midrst_state: in_ready=%b out_valid=%b s=%h expected 1/0/0000",
               bus.in_ready, bus.out_valid, bus.s);
    end
    send(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
    wait_valid(cyc, ok);
    e = sb_q.pop_front();
    got = {bus.s, bus.c_out, bus.ovf};
    n_checks++;
    if (!ok || cyc != 4 || got !== e || bus.s !== 16'h2345) begin
      n_fail++;
      $display("FAIL midrst_result: got %h after %0d cycles expected %h after 4", got, cyc, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [WIDTH-1:0] a, b;
    logic             ci, sb;
    int               cyc, wait_n;
    bit               ok;
    exp_t             e, got;
    longint           t_acc, t_prev;
    bus.out_ready = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 20; i++) begin
      a  = 16'($urandom);
      b  = 16'($urandom);
      ci = 1'($urandom_range(0, 1));
      sb = 1'($urandom_range(0, 1));
      bus.a = a; bus.b = b; bus.c_in = ci; bus.sub = sb;
      bus.in_valid = 1'b1;
      sb_q.push_back(model(a, b, ci, sb));
      wait_n = 0;
      while (bus.in_ready !== 1'b1 && wait_n < 20) begin
        @(posedge clk); #1;
        wait_n++;
      end
      @(posedge clk); #1;       // accept edge
      t_acc = $time;
      if (i == 19) bus.in_valid = 1'b0;
      if (i > 0) begin
        n_checks++;
        if ((t_acc - t_prev) != 60) begin
          n_fail++;
          $display("FAIL b2b_spacing_%0d: got %0d time units expected 60", i, t_acc - t_prev);
        end
      end
      t_prev = t_acc;
      wait_valid(cyc, ok);
      e = sb_q.pop_front();
      got = {bus.s, bus.c_out, bus.ovf};
      n_checks++;
      if (!ok || got !== e) begin
        n_fail++;
        $display("FAIL b2b_result_%0d: a=%h b=%h ci=%b sub=%b got %h expected %h",
                 i, a, b, ci, sb, got, e);
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (sb_q.size() != 0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: queue=%0d out_valid=%b expected 0/0", sb_q.size(), bus.out_valid);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a         = '0;
    bus.b         = '0;
    bus.c_in      = 1'b0;
    bus.sub       = 1'b0;
    test_reset();
    test_add_basic();
    test_arith();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
